pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Owns the program counter of the pipelined core and sequences next-fetch-address selection: sequential PC+4, taken branch resolved in EX, and jump decoded in ID.
- Computes the branch target as branch PC + 4 + (sign-extended immediate shifted left by 2).
- Drives the IF/ID and ID/EX flush signals and the fetch enable, and honours stall and halt requests.
- Sits between the hazard unit and instruction memory, and replaces the free-running PC register.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
CNT_W, 16, width of the saturating redirect counter.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
stall_i  in  1  hazard-unit stall; holds the PC.
halt_i  in  1  halt request; sampled only in RUN.
br_valid_i  in  1  EX stage holds a resolved branch.
br_taken_i  in  1  branch condition true; qualified by br_valid_i.
br_pc_i  in  32  PC of the branch instruction in EX.
br_imm_i  in  32  sign-extended 16-bit branch offset, in words.
jmp_valid_i  in  1  ID stage holds a J-type jump.
jmp_pc_i  in  32  PC of the jump instruction in ID.
jmp_idx_i  in  26  jump index field.
pc_o  out  32  current fetch address.
pc_plus4_o  out  32  pc_o + 4, modulo 2^32.
fetch_en_o  out  1  instruction memory read enable.
flush_ifid_o  out  1  clear the IF/ID register this cycle.
flush_idex_o  out  1  clear the ID/EX register this cycle.
halted_o  out  1  high while in HALT.
redirect_cnt_o  out  CNT_W  count of taken redirects (branch plus jump), saturating.

Behaviour:
- Reset (rst_n=0 at an edge):
  - pc_o=RESET_PC; state=BOOT; redirect_cnt_o=0; halted_o=0.
  - fetch_en_o=0, flush_ifid_o=0, flush_idex_o=0.
  - Reset overrides every input and applies mid-operation, including from HALT.
- FSM states and transitions:
  - BOOT: fetch_en_o=0 for exactly one cycle, PC held; -> RUN unconditionally.
  - RUN: fetch_en_o = ~stall_i.
  - HALT: entered from RUN when halt_i=1 and no redirect is taken that cycle. PC frozen, fetch_en_o=0, halted_o=1. Exit only by reset; all inputs are ignored.
- Branch target:
  - br_tgt = br_pc_i + 4 + {br_imm_i[29:0],2'b00}, 32-bit, modulo 2^32.
  - Negative offsets work through two's complement.
- Jump target:
  - jmp_tgt = {jp4[31:28], jmp_idx_i, 2'b00}, where jp4 = jmp_pc_i + 4.
- Next-PC priority in RUN, evaluated combinationally and applied at the edge:
  1. Branch redirect (br_valid_i & br_taken_i): pc<=br_tgt; flush_ifid_o=1 and flush_idex_o=1 in the same cycle. Overrides stall_i, jmp_valid_i and halt_i.
  2. Jump redirect (jmp_valid_i, no branch redirect): pc<=jmp_tgt; flush_ifid_o=1, flush_idex_o=0. Overrides stall_i and halt_i.
  3. stall_i=1: pc held, no flush.
  4. Otherwise: pc<=pc_o+4; wraps from 32'hFFFF_FFFC to 32'h0000_0000.
- Flush outputs:
  - Purely combinational from the current-cycle inputs.
  - Forced to 0 in BOOT and HALT and during reset.
- Not-taken branch (br_valid_i=1, br_taken_i=0): no effect; sequential or stall rules apply.
- Redirect counter:
  - Increments by 1 on each edge where a branch or jump redirect is applied.
  - Saturates at 2^CNT_W-1; cleared only by reset.
- PC alignment: pc_o[1:0] is always 0; no misalignment path exists.
- Latency: a redirect decided in cycle N appears on pc_o in cycle N+1.

Test Plan:
1. Reset, then release with RESET_PC=0, no inputs -> fetch_en_o=0 for 1 cycle (BOOT); then pc_o=0,4,8,12 on consecutive cycles.
2. At pc_o=0x40, br_valid_i=1, br_taken_i=1, br_pc_i=0x38, br_imm_i=0xFFFF_FFFE -> flush_ifid_o=1 and flush_idex_o=1 that cycle; next pc_o=0x34; redirect_cnt_o=1.
3. Same cycle: jmp_valid_i=1 (jmp_pc_i=0x1000_0010, jmp_idx_i=0x0000100) plus stall_i=1 and a taken branch with br_tgt=0x200 -> pc_o=0x200 next cycle; flush_idex_o=1; count +1 only.
4. Jump alone with jmp_pc_i=0x1000_0010, jmp_idx_i=0x0000100 and stall_i=1 -> pc_o=0x1000_0400 next cycle; flush_ifid_o=1, flush_idex_o=0.
5. stall_i held 3 cycles at pc_o=0x20 -> pc_o stays 0x20, fetch_en_o=0, no flush; resumes at 0x24. Separately, pc_o=0xFFFF_FFFC with no stall -> next pc_o=0x0.
6. halt_i=1 in RUN with no redirect -> halted_o=1 next cycle, PC frozen through later branches. Then rst_n=0 for one edge -> pc_o=RESET_PC, state BOOT, counter 0.
7. With CNT_W=4, apply 20 redirects -> redirect_cnt_o holds at 15.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Owns the fetch program counter of the pipelined core. Selects the next
//   fetch address from: taken branch resolved in EX (highest priority), jump
//   decoded in ID, stall hold, or sequential PC+4. Drives the IF/ID and ID/EX
//   flushes, the instruction-memory read enable, and a saturating count of
//   applied redirects. A halt request parks the sequencer until reset.
//
// Ports
//   clk            : system clock, all state updates on the rising edge
//   rst_n          : synchronous active-low reset
//   stall_i        : hazard-unit stall, holds the PC
//   halt_i         : halt request, honoured only while running
//   br_valid_i     : EX holds a resolved branch
//   br_taken_i     : branch condition true (qualified by br_valid_i)
//   br_pc_i        : PC of the branch in EX
//   br_imm_i       : sign-extended branch word offset
//   jmp_valid_i    : ID holds a J-type jump
//   jmp_pc_i       : PC of the jump in ID
//   jmp_idx_i      : 26-bit jump index
//   pc_o           : current fetch address
//   pc_plus4_o     : pc_o + 4 (mod 2^32)
//   fetch_en_o     : instruction memory read enable
//   flush_ifid_o   : clear IF/ID this cycle
//   flush_idex_o   : clear ID/EX this cycle
//   halted_o       : high while halted
//   redirect_cnt_o : saturating count of applied branch/jump redirects
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             halt_i,
    input  logic             br_valid_i,
    input  logic             br_taken_i,
    input  logic [31:0]      br_pc_i,
    input  logic [31:0]      br_imm_i,
    input  logic             jmp_valid_i,
    input  logic [31:0]      jmp_pc_i,
    input  logic [25:0]      jmp_idx_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      pc_plus4_o,
    output logic             fetch_en_o,
    output logic             flush_ifid_o,
    output logic             flush_idex_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] redirect_cnt_o
);

    localparam logic [1:0] BOOT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [31:0]      pc;
    logic [31:0]      pc_next;
    logic [31:0]      pc_plus4;
    logic [31:0]      br_tgt;
    logic [31:0]      jp4;
    logic [31:0]      jmp_tgt;
    logic [CNT_W-1:0] cnt;
    logic             in_run;
    logic             br_take;
    logic             jmp_take;
    logic             redirect;

    // Only the low 30 bits of the word offset survive the <<2, and only the
    // top nibble of the jump's PC+4 region is kept.
    logic unused_bits;
    assign unused_bits = &{1'b0, br_imm_i[31:30], jp4[27:0]};

    assign pc_plus4 = pc + 32'd4;
    assign br_tgt   = br_pc_i + 32'd4 + {br_imm_i[29:0], 2'b00};
    assign jp4      = jmp_pc_i + 32'd4;
    assign jmp_tgt  = {jp4[31:28], jmp_idx_i, 2'b00};

    // A branch redirect wins over a jump in the same cycle; both are only
    // honoured while running.
    assign in_run   = (state == RUN);
    assign br_take  = in_run & br_valid_i & br_taken_i;
    assign jmp_take = in_run & jmp_valid_i & ~br_take;
    assign redirect = br_take | jmp_take;

    always_comb begin
        pc_next    = pc;
        state_next = state;
        case (state)
            BOOT: state_next = RUN;
            RUN: begin
                if (br_take) begin
                    pc_next = br_tgt;
                end else if (jmp_take) begin
                    pc_next = jmp_tgt;
                end else if (halt_i) begin
                    // PC freezes on the cycle the halt is accepted.
                    state_next = HALT;
                end else if (!stall_i) begin
                    pc_next = pc_plus4;
                end
            end
            HALT: state_next = HALT;
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= BOOT;
            pc    <= RESET_PC;
            cnt   <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (redirect && (cnt != CNT_MAX)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Control outputs are combinational and gated by rst_n so that nothing
    // fetches or flushes while reset is asserted.
    assign fetch_en_o     = rst_n & in_run & ~stall_i;
    assign flush_ifid_o   = rst_n & redirect;
    assign flush_idex_o   = rst_n & br_take;
    assign halted_o       = (state == HALT);
    assign pc_o           = pc;
    assign pc_plus4_o     = pc_plus4;
    assign redirect_cnt_o = cnt;

endmodule
